// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: sequences multi-cycle MULT/DIV and single-cycle MTHI/MTLO into hilo_reg,
// stalling the pipeline while an operation is in flight.
module hilo_muldiv_ctrl #(
   parameter int          MUL_LAT = 3,
   parameter logic [31:0] DIV0_Q  = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic [31:0] hi_cur,
   input  logic [31:0] lo_cur,
   output logic        hilo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata,
   output logic        stall_req,
   output logic        busy
);
   localparam int CW = (MUL_LAT > 32) ? $clog2(MUL_LAT) : 5;
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [31:0] res_hi, res_lo, dvs, dvd_raw, mag_a, mag_b, diff, r_nx, q_nx;
   logic [63:0] prod_s, prod_u;
   logic [32:0] sh;
   logic neg_q, neg_r, div0, ena, is_mul, is_div, start, mt, wr_done, sa, sb, ge;

   always_comb begin
      ena    = rst & ~flush;
      is_mul = (op == 3'd1) | (op == 3'd2);
      is_div = (op == 3'd3) | (op == 3'd4);
      start  = ena & op_valid & (state == IDLE) & (is_mul | is_div);
      mt     = ena & op_valid & (state == IDLE) & ((op == 3'd5) | (op == 3'd6));
      sa     = (op == 3'd3) & src_a[31];
      sb     = (op == 3'd3) & src_b[31];
      mag_a  = sa ? -src_a : src_a;
      mag_b  = sb ? -src_b : src_b;
      prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
      prod_u = {32'd0, src_a} * {32'd0, src_b};
      // restoring step: partial remainder lives in res_hi, dividend/quotient shifts through res_lo
      sh     = {res_hi, res_lo[31]};
      ge     = sh >= {1'b0, dvs};
      diff   = sh[31:0] - dvs;
      r_nx   = ge ? diff : sh[31:0];
      q_nx   = {res_lo[30:0], ge};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush) state_nx = IDLE;
      else
         case (state)
            IDLE:    state_nx = start ? (is_mul ? MUL : DIV) : IDLE;
            MUL:     state_nx = (cnt == '0) ? DONE : MUL;
            DIV:     state_nx = (cnt == '0) ? DONE : DIV;
            default: state_nx = IDLE;
         endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         res_hi  <= '0;
         res_lo  <= '0;
         dvs     <= '0;
         dvd_raw <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         div0    <= 1'b0;
      end else if (start) begin
         if (is_mul) begin
            {res_hi, res_lo} <= (op == 3'd1) ? prod_s : prod_u;
            cnt              <= CW'(MUL_LAT - 1);
         end else begin
            res_hi  <= '0;
            res_lo  <= mag_a;
            dvs     <= mag_b;
            dvd_raw <= src_a;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            div0    <= (src_b == '0);
            cnt     <= CW'(31);
         end
      end else if (state == MUL) begin
         cnt <= cnt - 1'b1;
      end else if (state == DIV) begin
         cnt <= cnt - 1'b1;
         if (cnt == '0) begin
            res_lo <= div0 ? DIV0_Q : (neg_q ? -q_nx : q_nx);
            res_hi <= div0 ? dvd_raw : (neg_r ? -r_nx : r_nx);
         end else begin
            res_hi <= r_nx;
            res_lo <= q_nx;
         end
      end
   end

   always_comb begin
      wr_done   = ena & (state == DONE);
      hilo_we   = wr_done | mt;
      hi_wdata  = wr_done ? res_hi : mt ? ((op == 3'd5) ? src_a : hi_cur) : '0;
      lo_wdata  = wr_done ? res_lo : mt ? ((op == 3'd6) ? src_a : lo_cur) : '0;
      stall_req = start | (ena & ((state == MUL) | (state == DIV)));
      busy      = state != IDLE;
   end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed vectors against hand-computed HI/LO results, stall lengths,
// write pulses, flush and reset behaviour.
module tb_hilo_muldiv_ctrl;
   logic        clk = 1'b0, rst = 1'b0, op_valid = 1'b0, flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] src_a = '0, src_b = '0, hi_cur = '0, lo_cur = '0;
   logic        hilo_we, stall_req, busy;
   logic [31:0] hi_wdata, lo_wdata, mhi = '0, mlo = '0;
   int          vecs = 0, errs = 0, we_cnt = 0, w0;

   hilo_muldiv_ctrl dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
      .flush(flush), .hi_cur(hi_cur), .lo_cur(lo_cur), .hilo_we(hilo_we),
      .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .stall_req(stall_req), .busy(busy)
   );

   always #5 clk = ~clk;

   // stand-in for hilo_reg: captures every write and counts write pulses
   always @(posedge clk) begin
      if (hilo_we) begin
         mhi    <= hi_wdata;
         mlo    <= lo_wdata;
         we_cnt <= we_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // call at posedge+1; leaves the bench at posedge+1 of the cycle after DONE
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall,
                         input logic [31:0] eh, input logic [31:0] el);
      int n = 0;
      int w = we_cnt;
      op_valid = 1'b1; op = o; src_a = a; src_b = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!stall_req) break;
         n++;
      end
      chk({tag, " stall_cycles"}, 64'(n), 64'(exp_stall));
      chk({tag, " done_we"}, 64'(hilo_we), 64'd1);
      chk({tag, " done_busy"}, 64'(busy), 64'd1);
      chk({tag, " wdata"}, {hi_wdata, lo_wdata}, {eh, el});
      @(posedge clk); #1;
      op_valid = 1'b0; op = 3'd0;
      chk({tag, " hilo"}, {mhi, mlo}, {eh, el});
      chk({tag, " we_pulses"}, 64'(we_cnt - w), 64'd1);
   endtask

   initial begin
      #2;
      chk("reset stall", 64'(stall_req), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset we", 64'(hilo_we), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      run_op("mult_neg3x5", 3'd1, 32'hFFFFFFFD, 32'd5, 4, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_op("div_neg7d2", 3'd3, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu_100d7", 3'd4, 32'd100, 32'd7, 33, 32'h00000002, 32'h0000000E);
      run_op("divu_by0", 3'd4, 32'h00001234, 32'd0, 33, 32'h00001234, 32'hFFFFFFFF);
      run_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 32'hFFFFFFFE, 32'h00000001);
      run_op("div_7dneg2", 3'd3, 32'd7, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD);
      run_op("div_by0_signed", 3'd3, 32'hFFFFFFF9, 32'd0, 33, 32'hFFFFFFF9, 32'hFFFFFFFF);

      // MTHI / MTLO: same-cycle write, no stall
      hi_cur = 32'h00000022; lo_cur = 32'h00000011;
      op_valid = 1'b1; op = 3'd5; src_a = 32'hDEADBEEF;
      @(negedge clk);
      chk("mthi we", 64'(hilo_we), 64'd1);
      chk("mthi wdata", {hi_wdata, lo_wdata}, {32'hDEADBEEF, 32'h00000011});
      chk("mthi stall", 64'(stall_req), 64'd0);
      @(posedge clk); #1;
      op = 3'd6; src_a = 32'hCAFEF00D;
      @(negedge clk);
      chk("mtlo we", 64'(hilo_we), 64'd1);
      chk("mtlo wdata", {hi_wdata, lo_wdata}, {32'h00000022, 32'hCAFEF00D});
      chk("mtlo stall", 64'(stall_req), 64'd0);
      @(posedge clk); #1;
      chk("mtlo hilo", {mhi, mlo}, {32'h00000022, 32'hCAFEF00D});

      // ops 0 and 7 do nothing
      op = 3'd0;
      @(negedge clk);
      chk("op0 we", 64'(hilo_we), 64'd0);
      chk("op0 stall", 64'(stall_req), 64'd0);
      @(posedge clk); #1;
      op = 3'd7;
      @(negedge clk);
      chk("op7 we", {63'd0, hilo_we | stall_req}, 64'd0);
      @(posedge clk); #1;
      chk("op7 busy", 64'(busy), 64'd0);
      op_valid = 1'b0; op = 3'd0;

      // flush in the 10th DIV cycle
      w0 = we_cnt;
      op_valid = 1'b1; op = 3'd4; src_a = 32'd100; src_b = 32'd7;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush stall", 64'(stall_req), 64'd0);
      chk("flush we", 64'(hilo_we), 64'd0);
      chk("flush busy_div", 64'(busy), 64'd1);
      @(posedge clk); #1;
      flush = 1'b0; op_valid = 1'b0; op = 3'd0;
      @(negedge clk);
      chk("flush idle", 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk("flush no_write", 64'(we_cnt - w0), 64'd0);
      run_op("mult_after_flush", 3'd1, 32'h80000000, 32'h80000000, 4, 32'h40000000, 32'h00000000);

      // reset during MUL
      w0 = we_cnt;
      op_valid = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd4;
      @(posedge clk); #1;
      chk("rst pre busy", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      chk("rst stall", 64'(stall_req), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst we", 64'(hilo_we), 64'd0);
      chk("rst wdata", {hi_wdata, lo_wdata}, 64'd0);
      repeat (2) @(posedge clk);
      #1 op_valid = 1'b0; op = 3'd0; rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("rst no_write", 64'(we_cnt - w0), 64'd0);
      chk("rst idle", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
